// File: rtl/button_event.sv
// Classifies debounced button presses as short, long or held-with-auto-repeat
// and emits registered single-cycle event pulses for the mode controller.
module button_event #(
  parameter int LONG_CYC   = 1000,
  parameter int REPEAT_CYC = 200,
  parameter int CNT_W      = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  if (LONG_CYC < 2 || LONG_CYC > (1 << CNT_W) - 1) begin : g_bad_long_cyc
    $error("button_event: LONG_CYC out of range for CNT_W");
  end
  if (REPEAT_CYC < 1 || REPEAT_CYC > (1 << CNT_W) - 1) begin : g_bad_repeat_cyc
    $error("button_event: REPEAT_CYC out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      press_cnt_q <= '0;
      rep_cnt_q   <= '0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      short_q     <= short_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      held_q      <= held_d;
    end
  end

  // Reaching the long threshold moves to HELD, so press_cnt can never overflow.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_level) begin
          state_d     = PRESSED;
          press_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_d = IDLE;
        end else if (press_cnt_q == LONG_LAST) begin
          state_d   = HELD;
          rep_cnt_d = '0;
        end else begin
          press_cnt_d = press_cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_level) begin
          state_d = IDLE;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A release always takes priority over a long or repeat event on the same edge.
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      PRESSED: begin
        short_d = !btn_level;
        long_d  = btn_level && (press_cnt_q == LONG_LAST);
      end
      HELD: begin
        repeat_d = btn_level && (rep_cnt_q == REP_LAST);
      end
      default: ;
    endcase
    held_d = (state_d == HELD);
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed self-checking bench for button_event with LONG_CYC=8, REPEAT_CYC=3.
// Each scenario drives btn_level from a per-edge bit pattern and compares
// {short, long, repeat, held} after every edge against hand-computed masks.
module tb_button_event;

   logic clk;
   logic rst;
   logic btn_level;
   logic short_pulse;
   logic long_pulse;
   logic repeat_pulse;
   logic held;

   int checks;
   int errors;

   button_event #(
      .LONG_CYC  (8),
      .REPEAT_CYC(3),
      .CNT_W     (11)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_level   (btn_level),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .repeat_pulse(repeat_pulse),
      .held        (held)
   );

   // Free-running 10-unit clock; rising edges land at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed {short,long,repeat,held}=%b expected %b", tag, observed, expected);
      end
   endtask

   // Edge k samples pat[k]; after edge k the outputs must equal the k-th bits
   // of the expected masks. Edge 0 is the edge at which IDLE first sees a press.
   task automatic applyStimulus(input string name, input logic [31:0] pat, input int edges,
                                input logic [31:0] shortMask, input logic [31:0] longMask,
                                input logic [31:0] repMask, input logic [31:0] heldMask);
      for (int k = 0; k < edges; k++) begin
         btn_level = pat[k];
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s edge %0d", name, k),
                     {short_pulse, long_pulse, repeat_pulse, held},
                     {shortMask[k], longMask[k], repMask[k], heldMask[k]});
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      btn_level = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset state", {short_pulse, long_pulse, repeat_pulse, held}, 4'b0000);
      rst = 1'b0;

      // Press held for five edges, released at edge 5: one short pulse.
      applyStimulus("short5", 32'h0000_001F, 8, 32'h0000_0020, 32'h0, 32'h0, 32'h0);

      // Release sampled exactly where press_cnt hits the threshold: still short.
      applyStimulus("thresh8", 32'h0000_00FF, 11, 32'h0000_0100, 32'h0, 32'h0, 32'h0);

      // One more edge of hold: long at edge 8, held for one cycle, no short.
      applyStimulus("thresh9", 32'h0000_01FF, 12, 32'h0, 32'h0000_0100, 32'h0, 32'h0000_0100);

      // Long hold: long at 8, repeats at 11/14/17, release at 20 collides with a repeat.
      applyStimulus("long20", 32'h000F_FFFF, 24, 32'h0, 32'h0000_0100, 32'h0002_4800, 32'h000F_FF00);

      // Release lands on the edge a repeat would fire: repeat suppressed, held drops.
      applyStimulus("collide17", 32'h0001_FFFF, 20, 32'h0, 32'h0000_0100, 32'h0000_4800, 32'h0001_FF00);

      // One-cycle glitch then immediate re-press: two shorts two cycles apart.
      applyStimulus("glitch", 32'h0000_0005, 6, 32'h0000_000A, 32'h0, 32'h0, 32'h0);

      // Reach HELD, then assert reset mid-cycle with no clock edge in between.
      applyStimulus("pre-reset", 32'h0000_03FF, 10, 32'h0, 32'h0000_0100, 32'h0, 32'h0000_0300);
      rst = 1'b1;
      #1;
      checkOutput("async reset in HELD", {short_pulse, long_pulse, repeat_pulse, held}, 4'b0000);
      @(posedge clk);
      #1;
      checkOutput("reset held over edge", {short_pulse, long_pulse, repeat_pulse, held}, 4'b0000);
      rst = 1'b0;

      // Button still down after reset: first edge is a fresh press, long 8 edges later.
      applyStimulus("post-reset", 32'h0000_07FF, 14, 32'h0, 32'h0000_0100, 32'h0, 32'h0000_0700);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net so a stuck run still reports and terminates.
   initial begin
      #20000;
      $display("[TB] FAIL timeout: observed no completion expected finish before time 20000");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] timeout");
   end

endmodule
